audio_input: RTL

- PDM capture path, the write-side counterpart of the audio output serializer.
- Samples the 1-bit PDM microphone stream once per clk (1.5 MHz) and packs 16 consecutive bits into one word, LSB first: the first bit sampled goes to bit 0.
- Writes each word into the DelayBuffer at an auto-incrementing, wrapping address using a valid/ready handshake.
- Reports per-word pulse density (level) and a sticky overrun flag.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/audio_input_if.sv | 26 ++
 rtl/pdm_deserializer.sv | 58 +++++
 rtl/audio_input.sv | 112 +++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture and playback paths.
package audio_pkg;

  localparam int unsigned MEM_WIDTH     = 16;
  localparam int unsigned MEM_DEPTH     = 65536;
  localparam int unsigned ADDR_WIDTH    = 16;
  localparam int unsigned BITS_PER_WORD = MEM_WIDTH;
  localparam int unsigned LEVEL_WIDTH   = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_PEND = 1'b1
  } wr_state_e;

  // Number of ones in a word; 16 fits in LEVEL_WIDTH bits without wrapping.
  function automatic logic [LEVEL_WIDTH-1:0] popcount(input logic [BITS_PER_WORD-1:0] w);
    logic [LEVEL_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < int'(BITS_PER_WORD); i++) begin
      n = n + LEVEL_WIDTH'(w[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/audio_input_if.sv
// Write port between the PDM capture path and the DelayBuffer.
interface audio_input_if #(
  parameter int unsigned MEM_WIDTH  = audio_pkg::MEM_WIDTH,
  parameter int unsigned ADDR_WIDTH = audio_pkg::ADDR_WIDTH
);

  logic                  write_enable;
  logic [MEM_WIDTH-1:0]  write_data;
  logic [ADDR_WIDTH-1:0] write_address;
  logic                  wr_ready;

  modport master (
    output write_enable,
    output write_data,
    output write_address,
    input  wr_ready
  );

  modport slave (
    input  write_enable,
    input  write_data,
    input  write_address,
    output wr_ready
  );

endinterface

// File: rtl/pdm_deserializer.sv
// Packs the 1-bit PDM stream LSB-first into words and flags each completed word.
module pdm_deserializer #(
  parameter int unsigned MEM_WIDTH = audio_pkg::MEM_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable_i,
  input  logic                               pdm_i,
  output logic                               word_done_c,
  output logic [MEM_WIDTH-1:0]               word_c,
  output logic [audio_pkg::LEVEL_WIDTH-1:0]  level_c
);
  import audio_pkg::*;

  localparam int unsigned CW = $clog2(MEM_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(MEM_WIDTH - 1);

  cap_state_e           state_q, state_d;
  logic [CW-1:0]        bit_count_q, bit_count_d;
  logic [MEM_WIDTH-1:0] shift_q, shift_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i)  state_d = CAPTURE;
      CAPTURE: if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bit_count is 0 in IDLE, so the first enabled edge lands in bit 0 either way.
  always_comb begin
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    if (enable_i) begin
      shift_d[bit_count_q] = pdm_i;
      bit_count_d = (bit_count_q == LAST_BIT) ? '0 : bit_count_q + CW'(1);
    end else begin
      bit_count_d = '0;
    end
    word_done_c = enable_i && (state_q == CAPTURE) && (bit_count_q == LAST_BIT);
    word_c      = shift_d;
    level_c     = popcount(BITS_PER_WORD'(shift_d));
  end

endmodule

// File: rtl/audio_input.sv
// PDM capture path: deserializes microphone bits and writes words to the DelayBuffer.
module audio_input #(
  parameter int unsigned MEM_WIDTH  = audio_pkg::MEM_WIDTH,
  parameter int unsigned MEM_DEPTH  = audio_pkg::MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = audio_pkg::ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 PDM_in,
  audio_input_if.master        wr,
  output logic [4:0]           level,
  output logic                 overrun
);
  import audio_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic                  word_done_c;
  logic [MEM_WIDTH-1:0]  word_c;
  logic [4:0]            level_c;
  logic                  accept_c;

  wr_state_e             wr_state_q, wr_state_d;
  logic                  write_enable_q, write_enable_d;
  logic [MEM_WIDTH-1:0]  write_data_q, write_data_d;
  logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
  logic [4:0]            level_q, level_d;
  logic                  overrun_q, overrun_d;

  pdm_deserializer #(.MEM_WIDTH(MEM_WIDTH)) u_deser (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_i    (enable),
    .pdm_i       (PDM_in),
    .word_done_c (word_done_c),
    .word_c      (word_c),
    .level_c     (level_c)
  );

  assign accept_c = write_enable_q & wr.wr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q      <= WR_IDLE;
      write_enable_q  <= 1'b0;
      write_data_q    <= '0;
      write_address_q <= '0;
      level_q         <= '0;
      overrun_q       <= 1'b0;
    end else begin
      wr_state_q      <= wr_state_d;
      write_enable_q  <= write_enable_d;
      write_data_q    <= write_data_d;
      write_address_q <= write_address_d;
      level_q         <= level_d;
      overrun_q       <= overrun_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (word_done_c)               wr_state_d = WR_PEND;
      WR_PEND: if (accept_c && !word_done_c)  wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // A word completing while the previous one is still unaccepted is dropped.
  always_comb begin
    write_enable_d  = write_enable_q;
    write_data_d    = write_data_q;
    write_address_d = write_address_q;
    level_d         = level_q;
    overrun_d       = overrun_q;

    if (word_done_c) level_d = level_c;
    if (!enable)     overrun_d = 1'b0;

    case (wr_state_q)
      WR_IDLE: begin
        if (word_done_c) begin
          write_data_d   = word_c;
          write_enable_d = 1'b1;
        end
      end
      WR_PEND: begin
        if (accept_c) begin
          write_address_d = (write_address_q == ADDR_LAST) ? '0
                                                           : write_address_q + ADDR_WIDTH'(1);
          if (word_done_c) begin
            write_data_d   = word_c;
            write_enable_d = 1'b1;
          end else begin
            write_enable_d = 1'b0;
          end
        end else if (word_done_c) begin
          overrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign wr.write_enable  = write_enable_q;
  assign wr.write_data    = write_data_q;
  assign wr.write_address = write_address_q;
  assign level            = level_q;
  assign overrun          = overrun_q;

endmodule
